hazard_scoreboard_unit: RTL and testbench

- Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID/EX pipeline registers.
- Detects load-use hazards, including loads whose data arrives several cycles after EX, and tracks an in-flight multi-cycle multiply/divide unit.
- Generates a multi-cycle front-end flush on taken branches and jumps resolved in EX.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard_unit.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller beside the ID/EX registers: load-use and mul/div
// interlocks, multi-cycle front-end flush on EX redirects, and a stall counter.
module hazard_scoreboard_unit #(
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int MD_LAT       = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_to_reg,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_mem_write,
    input  logic              id_md_start,
    input  logic              md_start,
    input  logic [REG_AW-1:0] md_dst,
    input  logic              ex_jump,
    input  logic              ex_branch,
    input  logic              ex_cond,
    output logic              stall,
    output logic              flush,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam int MD_CW = 4;
    localparam int FL_CW = 2;
    localparam logic [MD_CW-1:0] MD_INIT = MD_CW'(MD_LAT);
    localparam logic [FL_CW-1:0] FL_INIT = FL_CW'(FLUSH_CYCLES - 1);

    logic [MD_CW-1:0]  md_cnt;
    logic [REG_AW-1:0] md_dst_q;
    logic [FL_CW-1:0]  flush_cnt;

    logic taken;
    logic ex_hazard;
    logic chain_hazard;
    logic md_hazard;
    logic any_hazard;

    always_comb begin
        taken   = ex_jump || (ex_branch && ex_cond);
        flush   = taken || (flush_cnt != '0);
        md_busy = (md_cnt != '0);
    end

    // Store data (rt) behind a load is forwarded at MEM, so it never stalls here.
    always_comb begin
        ex_hazard = ex_mem_to_reg && (ex_rt != '0) &&
                    ((id_uses_rs && (ex_rt == id_rs)) ||
                     (id_uses_rt && (ex_rt == id_rt) && !id_mem_write));
    end

    // Loads whose data arrives after EX are remembered for LOAD_LAT-1 cycles.
    generate
        if (LOAD_LAT > 1) begin : g_chain
            localparam int DEPTH = LOAD_LAT - 1;

            logic [DEPTH-1:0]  pend_valid;
            logic [REG_AW-1:0] pend_reg [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_valid <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        pend_reg[i] <= '0;
                    end
                end else begin
                    pend_valid[0] <= ex_mem_to_reg && (ex_rt != '0) && !flush;
                    pend_reg[0]   <= ex_rt;
                    for (int i = 1; i < DEPTH; i++) begin
                        pend_valid[i] <= pend_valid[i-1];
                        pend_reg[i]   <= pend_reg[i-1];
                    end
                end
            end

            always_comb begin
                chain_hazard = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (pend_valid[i] &&
                        ((id_uses_rs && (pend_reg[i] == id_rs)) ||
                         (id_uses_rt && (pend_reg[i] == id_rt)))) begin
                        chain_hazard = 1'b1;
                    end
                end
            end
        end else begin : g_no_chain
            assign chain_hazard = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt   <= '0;
            md_dst_q <= '0;
        end else if (md_start && (md_cnt == '0)) begin
            md_cnt   <= MD_INIT;
            md_dst_q <= md_dst;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    always_comb begin
        md_hazard = (md_busy && (md_dst_q != '0) &&
                     ((id_uses_rs && (md_dst_q == id_rs)) ||
                      (id_uses_rt && (md_dst_q == id_rt)))) ||
                    (id_md_start && md_busy);
        any_hazard = ex_hazard || chain_hazard || md_hazard;
        stall      = any_hazard && !flush;
    end

    // A redirect arriving while the counter runs sits in an already-killed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (taken && (flush_cnt == '0)) begin
            flush_cnt <= FL_INIT;
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: expectations queued at drive time,
// popped and asserted against the combinational outputs before the next edge.
module tb_hazard_scoreboard_unit;

    localparam int AW = 5;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          ex_mem_to_reg;
    logic [AW-1:0] ex_rt;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic          id_mem_write;
    logic          id_md_start;
    logic          md_start;
    logic [AW-1:0] md_dst;
    logic          ex_jump;
    logic          ex_branch;
    logic          ex_cond;
    logic          stall;
    logic          flush;
    logic          md_busy;
    logic [PW-1:0] stall_cnt;

    typedef struct {
        string         tag;
        logic          stall;
        logic          flush;
        logic          busy;
        logic [PW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [PW-1:0] exp_cnt;
    int            checks;
    int            errors;

    hazard_scoreboard_unit #(
        .REG_AW(AW), .LOAD_LAT(3), .MD_LAT(4), .FLUSH_CYCLES(2), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_mem_write(id_mem_write), .id_md_start(id_md_start),
        .md_start(md_start), .md_dst(md_dst),
        .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_cond(ex_cond),
        .stall(stall), .flush(flush), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushExpect(input string tag, input logic s, input logic f, input logic b);
        exp_t e;
        e.tag   = tag;
        e.stall = s;
        e.flush = f;
        e.busy  = b;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        if (s && (exp_cnt != 4'hF)) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=none required=entry");
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (stall === e.stall) else begin
                errors++;
                $error("[TB] FAIL %s stall observed=%0b required=%0b", e.tag, stall, e.stall);
            end
            checks++;
            assert (flush === e.flush) else begin
                errors++;
                $error("[TB] FAIL %s flush observed=%0b required=%0b", e.tag, flush, e.flush);
            end
            checks++;
            assert (md_busy === e.busy) else begin
                errors++;
                $error("[TB] FAIL %s md_busy observed=%0b required=%0b", e.tag, md_busy, e.busy);
            end
            checks++;
            assert (stall_cnt === e.cnt) else begin
                errors++;
                $error("[TB] FAIL %s stall_cnt observed=%0d required=%0d", e.tag, stall_cnt, e.cnt);
            end
        end
    endtask

    task automatic driveIdle();
        ex_mem_to_reg = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mem_write = 1'b0; id_md_start = 1'b0;
        md_start = 1'b0; md_dst = '0; ex_jump = 1'b0; ex_branch = 1'b0; ex_cond = 1'b0;
    endtask

    task automatic applyStimulus(
        input logic ld, input logic [AW-1:0] ert,
        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
        input logic urs, input logic urt, input logic memw, input logic idmd,
        input logic mds, input logic [AW-1:0] mdd,
        input logic jmp, input logic br, input logic cond,
        input logic e_stall, input logic e_flush, input logic e_busy, input string tag);
        @(negedge clk);
        ex_mem_to_reg = ld; ex_rt = ert; id_rs = rs; id_rt = rt;
        id_uses_rs = urs; id_uses_rt = urt; id_mem_write = memw; id_md_start = idmd;
        md_start = mds; md_dst = mdd; ex_jump = jmp; ex_branch = br; ex_cond = cond;
        pushExpect(tag, e_stall, e_flush, e_busy);
        #2;
        checkOutput();
    endtask

    task automatic idleStep(input logic e_busy, input string tag);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_busy, tag);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = '0;
        rst_n   = 1'b0;
        driveIdle();
        #2;
        pushExpect("reset", 0, 0, 0);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // EX-stage load-use, store-data exemption and r0
        applyStimulus(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "t1_ld_rs");
        idleStep(0, "t1_cnt1");
        idleStep(0, "t1_drain");
        applyStimulus(1, 5, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_store");
        idleStep(0, "t1_drain2");
        idleStep(0, "t1_drain3");
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_r0");
        idleStep(0, "t1_r0_next");

        // Late load data tracked by the pending chain
        applyStimulus(1, 7, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_c0");
        applyStimulus(0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "t2_c1");
        applyStimulus(0, 0, 0, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "t2_c2_store");
        applyStimulus(0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_c3");

        // Mul/div busy window, RAW on md_dst, structural stall, restart ignored
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, "t3_c0");
        applyStimulus(0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "t3_c1");
        applyStimulus(0, 0, 3, 0, 1, 0, 0, 1, 1, 10, 0, 0, 0, 1, 0, 1, "t3_c2_struct");
        applyStimulus(0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "t3_c3");
        applyStimulus(0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "t3_c4");
        applyStimulus(0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t3_c5");

        // Flush beats stall; second redirect during flush is ignored
        applyStimulus(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "t4_c0");
        applyStimulus(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "t4_c1");
        applyStimulus(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t4_c2");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, "t4_j0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, "t4_j1");
        idleStep(0, "t4_j2");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "t4_not_taken");

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "t5_sat");
        end
        idleStep(0, "t5_cnt15");
        idleStep(0, "t5_drain");
        idleStep(0, "t5_drain2");

        // Asynchronous reset with mul/div in flight and a flush pending
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, "t5_md");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, "t5_jmp");
        @(negedge clk);
        driveIdle();
        pushExpect("t5_pending", 0, 1, 1);
        #1;
        checkOutput();
        rst_n   = 1'b0;
        exp_cnt = '0;
        pushExpect("t5_async_rst", 0, 0, 0);
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        idleStep(0, "t5_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
